// File: rtl/cbrt_pkg.sv
// ============================================================================
// Module   : cbrt_pkg
// Purpose  : Shared constants and FSM state encoding for the cbrt arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cbrt_pkg;

    localparam int CBRT_A_W = 8;
    localparam int CBRT_Y_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } cbrt_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; searches upward from ptr+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // Offset i=NUM_REQ wraps back to the pointer itself, so it has lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cbrt_arbiter.sv
// ============================================================================
// Module   : cbrt_arbiter
// Purpose  : Round-robin sharing of one cbrt core among NUM_REQ requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cbrt_arbiter
    import cbrt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int A_W     = CBRT_A_W,
    parameter int Y_W     = CBRT_Y_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_bi,
    input  logic [NUM_REQ*A_W-1:0] a_bi,
    output logic [NUM_REQ-1:0]     gnt_bo,
    output logic [NUM_REQ-1:0]     done_bo,
    output logic [Y_W-1:0]         y_bo,
    output logic                   busy_o,
    output logic                   core_start_o,
    output logic [A_W-1:0]         core_a_bo,
    input  logic [1:0]             core_busy_bi,
    input  logic [Y_W-1:0]         core_y_bi
);

    localparam int IDX_W = $clog2(NUM_REQ);

    cbrt_state_e       state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [A_W-1:0]    a_q, a_d;
    logic [Y_W-1:0]    y_q, y_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (req_bi),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            win_q   <= '0;
            a_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            a_q     <= a_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        a_d          = a_q;
        y_d          = y_q;
        gnt_bo       = '0;
        done_bo      = '0;
        core_start_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_bo  = pick_gnt;
                    a_d     = a_bi[int'(pick_idx)*A_W +: A_W];
                    win_d   = pick_idx;
                    ptr_d   = pick_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start_o = 1'b1;
                state_d      = ST_ARM;
            end
            // Core busy is not yet valid while it registers the start pulse.
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_busy_bi == 2'b00) begin
                    y_d     = core_y_bi;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                done_bo[win_q] = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign core_a_bo = a_q;
    assign y_bo      = y_q;

endmodule

`default_nettype wire

// File: tb/tb_cbrt_arbiter.sv
// Bench for cbrt_arbiter: behavioural core model, scoreboard of expected
// done/result pairs, and table-driven plus hand-written sequences.
`default_nettype none

module tb_cbrt_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_i = 1'b0;
    logic [N-1:0]   req_bi = '0;
    logic [N*8-1:0] a_bi = '0;
    logic [N-1:0]   gnt_bo, done_bo;
    logic [3:0]     y_bo;
    logic           busy_o, core_start_o;
    logic [7:0]     core_a_bo;
    logic [1:0]     core_busy_bi;
    logic [3:0]     core_y_bi;

    cbrt_arbiter #(.NUM_REQ(N), .A_W(8), .Y_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_bi       (req_bi),
        .a_bi         (a_bi),
        .gnt_bo       (gnt_bo),
        .done_bo      (done_bo),
        .y_bo         (y_bo),
        .busy_o       (busy_o),
        .core_start_o (core_start_o),
        .core_a_bo    (core_a_bo),
        .core_busy_bi (core_busy_bi),
        .core_y_bi    (core_y_bi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] cbrt(input logic [7:0] a);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(a)) r++;
        return 4'(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core model: busy rises the cycle after ARM and stays for busy_len cycles.
    int unsigned busy_len = 0;
    logic        pend;
    int unsigned cnt;
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            pend <= 1'b0;
            cnt <= 0;
            core_y_bi <= '0;
        end else if (core_start_o) begin
            pend <= 1'b1;
            core_y_bi <= cbrt(core_a_bo);
        end else if (pend) begin
            pend <= 1'b0;
            cnt <= busy_len;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign core_busy_bi = (cnt != 0) ? 2'(cnt % 3 + 1) : 2'b00;

    typedef struct { logic [N-1:0] mask; logic [3:0] y; } exp_t;
    exp_t       sb[$];
    int         glog[$];
    int         dlog[$];
    logic [7:0] last_gnt_a = '0;
    int         g_cyc = 0, d_cyc = 0, busy_last = 0;

    always @(negedge clk) begin
        if (rst_i) begin
            if (core_busy_bi != 0) busy_last = cyc;
            if (gnt_bo != 0) begin
                int idx;
                exp_t e;
                idx = 0;
                for (int i = 0; i < N; i++) if (gnt_bo[i]) idx = i;
                chk("gnt_onehot", 64'($countones(gnt_bo)), 64'd1);
                e.mask = gnt_bo;
                e.y = cbrt(a_bi[idx*8 +: 8]);
                sb.push_back(e);
                glog.push_back(idx);
                last_gnt_a = a_bi[idx*8 +: 8];
                g_cyc = cyc;
            end
            if (core_start_o) chk("core_a_at_start", 64'(core_a_bo), 64'(last_gnt_a));
            if (done_bo != 0) begin
                chk("done_vs_gnt_overlap", 64'(gnt_bo), 64'd0);
                d_cyc = cyc;
                dlog.push_back(int'(y_bo));
                if (sb.size() == 0) begin
                    chk("done_unexpected", 64'(done_bo), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_mask", 64'(done_bo), 64'(e.mask));
                    chk("done_y", 64'(y_bo), 64'(e.y));
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] req);
        @(posedge clk);
        #1;
        req_bi = req;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (glog.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (glog.size() < n) chk("grant_timeout", 64'(glog.size()), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(sb.size() == 0 && busy_o == 1'b0) && k < budget);
        if (!(sb.size() == 0 && busy_o == 1'b0)) chk("idle_timeout", 64'(sb.size()), 64'd0);
    endtask

    typedef struct { int idx; logic [7:0] a; int blen; int exp_y; } vec_t;
    vec_t tbl[6];

    initial begin
        int exp_order[4];
        int exp_res[4];

        tbl[0] = '{0, 8'd27,  3,  3};
        tbl[1] = '{1, 8'd64,  0,  4};
        tbl[2] = '{2, 8'd1,   1,  1};
        tbl[3] = '{3, 8'd216, 5,  6};
        tbl[4] = '{0, 8'd255, 20, 6};
        tbl[5] = '{2, 8'd7,   0,  1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({gnt_bo, done_bo, y_bo, core_start_o, core_a_bo, busy_o}), 64'd0);
        rst_i = 1'b1;

        // All four held: grants 0,1,2,3 with results 0,2,5,6.
        busy_len = 2;
        glog.delete();
        dlog.delete();
        a_bi = {8'd255, 8'd125, 8'd8, 8'd0};
        drive(4'b1111);
        wait_grants(4, 200);
        drive(4'b0000);
        wait_idle(100);
        exp_order = '{0, 1, 2, 3};
        exp_res   = '{0, 2, 5, 6};
        for (int i = 0; i < 4; i++) begin
            chk("all4_order", 64'((i < glog.size()) ? glog[i] : -1), 64'(exp_order[i]));
            chk("all4_result", 64'((i < dlog.size()) ? dlog[i] : -1), 64'(exp_res[i]));
        end

        // Fairness: only 0 and 2 held.
        glog.delete();
        a_bi = {8'd10, 8'd20, 8'd30, 8'd40};
        drive(4'b0101);
        wait_grants(4, 200);
        drive(4'b0000);
        wait_idle(100);
        exp_order = '{0, 2, 0, 2};
        chk("fair_count", 64'(glog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("fair_order", 64'((i < glog.size()) ? glog[i] : -1), 64'(exp_order[i]));

        // Table of single requests with varying core latency.
        for (int t = 0; t < 6; t++) begin
            glog.delete();
            busy_len = tbl[t].blen;
            a_bi = '0;
            a_bi[tbl[t].idx*8 +: 8] = tbl[t].a;
            drive(4'(1 << tbl[t].idx));
            wait_grants(1, 50);
            drive(4'b0000);
            wait_idle(100);
            chk("tbl_gnt_idx", 64'((glog.size() > 0) ? glog[0] : -1), 64'(tbl[t].idx));
            chk("tbl_y", 64'(y_bo), 64'(tbl[t].exp_y));
            chk("tbl_latency", 64'(d_cyc - g_cyc), 64'(4 + tbl[t].blen));
            if (tbl[t].blen > 0) chk("tbl_done_after_busy_fall", 64'(d_cyc), 64'(busy_last + 2));
        end

        // Withdrawal after grant still delivers done.
        glog.delete();
        busy_len = 2;
        a_bi = '0;
        a_bi[15:8] = 8'd68;
        drive(4'b0010);
        wait_grants(1, 50);
        drive(4'b0000);
        wait_idle(100);
        chk("wd_y", 64'(y_bo), 64'd4);
        chk("wd_gnt", 64'((glog.size() > 0) ? glog[0] : -1), 64'd1);

        // Withdrawal before grant: req1 raised while busy, dropped before RESP.
        glog.delete();
        busy_len = 8;
        a_bi = '0;
        a_bi[7:0] = 8'd50;
        a_bi[15:8] = 8'd9;
        drive(4'b0001);
        wait_grants(1, 50);
        drive(4'b0010);
        repeat (3) @(posedge clk);
        #1;
        req_bi = 4'b0000;
        wait_idle(100);
        repeat (3) @(posedge clk);
        chk("wd_pre_count", 64'(glog.size()), 64'd1);
        chk("wd_pre_first", 64'((glog.size() > 0) ? glog[0] : -1), 64'd0);

        // Mid-operation reset during WAIT aborts silently.
        glog.delete();
        busy_len = 10;
        a_bi = '0;
        a_bi[23:16] = 8'd100;
        drive(4'b0100);
        wait_grants(1, 50);
        drive(4'b0000);
        begin
            int k = 0;
            while (core_busy_bi == 0 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("mid_reach_wait", 64'(core_busy_bi != 0), 64'd1);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        sb.delete();
        #1;
        chk("mid_reset_outputs", 64'({gnt_bo, done_bo, y_bo, core_start_o, core_a_bo, busy_o}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;

        glog.delete();
        busy_len = 2;
        a_bi = '0;
        a_bi[7:0] = 8'd27;
        a_bi[31:24] = 8'd200;
        drive(4'b1001);
        wait_grants(1, 50);
        drive(4'b1000);
        wait_grants(2, 50);
        drive(4'b0000);
        wait_idle(100);
        chk("post_rst_first", 64'((glog.size() > 0) ? glog[0] : -1), 64'd0);
        chk("post_rst_second", 64'((glog.size() > 1) ? glog[1] : -1), 64'd3);
        chk("post_rst_y3", 64'(y_bo), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/cbrt_arbiter.md
Name: cbrt_arbiter

Overview:
- Shares one cbrt core (8-bit operand, 4-bit floor cube root) among NUM_REQ requesters.
- Arbitrates with round-robin priority, sequences the core's start/busy handshake, captures the result and returns it to the winning requester.
- Sits between requester logic and the core; the top level wires the core_* ports to the core's start_i, a_bi, busy_o and y_bo.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 8, operand width.
- Y_W, 4, result width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_bi  in  NUM_REQ  per-requester request level.
- a_bi  in  NUM_REQ*A_W  packed operands; requester k occupies bits [k*A_W +: A_W].
- gnt_bo  out  NUM_REQ  one-hot, one-cycle grant pulse.
- done_bo  out  NUM_REQ  one-hot, one-cycle result-valid pulse.
- y_bo  out  Y_W  result, valid while done_bo != 0.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- core_start_o  out  1  start pulse to the core.
- core_a_bo  out  A_W  operand to the core.
- core_busy_bi  in  2  core busy; nonzero means busy.
- core_y_bi  in  Y_W  core result.

Behaviour:
- Reset (rst_i=0, asynchronous) forces:
  - state IDLE;
  - gnt_bo, done_bo, y_bo, core_start_o, core_a_bo, busy_o all 0;
  - RR pointer to NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-operation aborts the job silently: no done pulse. The top is responsible for resetting the core in the same event.
- States:
  - IDLE: if req_bi != 0, pick the winner, searching upward from pointer+1 with wrap-around modulo NUM_REQ. Pulse gnt_bo[w], latch operand a_bi[w] into core_a_bo, latch w, set pointer=w, go ISSUE. If req_bi == 0, stay.
  - ISSUE: core_start_o=1 for exactly this cycle, core_a_bo stable. Go ARM.
  - ARM: one cycle. Ignore core_busy_bi while the core registers start. Go WAIT.
  - WAIT: stay while core_busy_bi != 0. When it reads 0, capture core_y_bi into y_bo and go RESP.
  - RESP: done_bo[w]=1 for one cycle, y_bo held. Go IDLE.
- core_a_bo holds its value from grant through RESP.
- y_bo holds the last result until the next RESP or reset.
- Minimum turnaround from grant to done is 4 cycles plus core busy length. Back-to-back jobs have one IDLE cycle between RESP and the next grant.
- Requester handshake:
  - hold req until its gnt pulse; the operand is sampled only in the grant cycle;
  - dropping req after grant does not cancel the job, and done is still delivered;
  - dropping req before grant simply withdraws it.
- Requests arriving outside IDLE wait; they are never lost while still asserted.
- Round-robin fairness: with all requests held, grants rotate 0,1,...,NUM_REQ-1,0,... A requester that just received done cannot win again while any other requester is asserting.
- gnt_bo and done_bo are never both nonzero in the same cycle, and each is at most one-hot.
- core_busy_bi must be nonzero in the cycle after ISSUE+1 for a nonzero-length computation. If it is already 0 in WAIT, the result is captured immediately; this is legal for a zero-latency core.

Decomposition:
- Shared package cbrt_pkg holds:
  - constants CBRT_A_W=8 and CBRT_Y_W=4;
  - the FSM state enum (IDLE, ISSUE, ARM, WAIT, RESP, 3-bit encoding).
- One natural sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner and index.
  - Reused by other shared-unit arbiters.
- The cbrt core is not instantiated inside cbrt_arbiter.

Test Plan:
- Single request: req0 with a=27 → gnt_bo=0001 one cycle; core_start_o one pulse with core_a_bo=27; done_bo=0001 with y_bo=3; busy_o back to 0.
- All four requests held, operands 0,8,125,255 → grants in order 0,1,2,3; done results 0,2,5,6 each on the matching done bit.
- Fairness: req0 and req2 held continuously → grant order 0,2,0,2. No grant to 1 or 3.
- Withdrawal: req1 drops the cycle after its grant, a=68 → done_bo=0010 with y_bo=4 still delivered. Raising req1 before grant with a=9, then dropping it → no grant to 1.
- Mid-operation reset: assert rst_i=0 during WAIT → outputs 0 immediately, no done pulse. After release, req3 with a=200 is granted first only if no lower index requests; with req0 also set, req0 wins first and y_bo=5 for req3 afterward.
- Busy edge cases: core model with busy never asserting → done after ARM+1 cycle with captured y. Core model with busy held 20 cycles → done exactly one cycle after busy falls.
